// File: rtl/vjtag_pkg.sv
// Shared constants for the virtual-JTAG memory bridge: instruction codes,
// default widths and the DR-scan tracking state.
package vjtag_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IR_BYPASS   = 2'b00,
        IR_SET_ADDR = 2'b01,
        IR_WRITE    = 2'b10,
        IR_READ     = 2'b11
    } ir_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } dr_state_e;

endpackage

// File: rtl/vjtag_mem_bridge.sv
// Virtual-JTAG to synchronous-memory bridge: address set/readback, write and
// auto-incrementing read through one shared DR shift register.
module vjtag_mem_bridge
    import vjtag_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              tck,
    input  logic              rst_n,
    input  logic              tdi,
    output logic              tdo,
    input  logic [1:0]        ir_in,
    output logic [1:0]        ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_uir,
    input  logic              virtual_state_e1dr,
    input  logic              virtual_state_pdr,
    input  logic              virtual_state_e2dr,
    input  logic              virtual_state_cir,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [ADDR_W-1:0] sr_q, sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bypass_q, bypass_d;
    logic              we_q, we_d;
    logic              wrap_q, wrap_d;
    dr_state_e         state_q, state_d;
    ir_e               ir;
    logic              load_addr, inc_addr;
    logic              unused_ok;

    assign ir        = ir_e'(ir_in);
    assign unused_ok = ^{virtual_state_e1dr, virtual_state_pdr,
                         virtual_state_e2dr, virtual_state_cir};

    // Shift and update only act after a capture since reset, so a reset in
    // the middle of a scan drops the partial DR and cannot trigger a write.
    always_comb begin
        sr_d      = sr_q;
        bypass_d  = bypass_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        state_d   = state_q;
        load_addr = 1'b0;
        inc_addr  = we_q;
        addr_d    = addr_q;
        wrap_d    = wrap_q;

        if (virtual_state_udr) begin
            state_d = ST_IDLE;
            if (state_q == ST_ARMED) begin
                case (ir)
                    IR_SET_ADDR: load_addr = 1'b1;
                    IR_WRITE: begin
                        wdata_d = sr_q[DATA_W-1:0];
                        we_d    = 1'b1;
                    end
                    IR_READ:     inc_addr = 1'b1;
                    default: ;
                endcase
            end
        end else if (virtual_state_cdr) begin
            state_d = ST_ARMED;
            case (ir)
                IR_BYPASS:   bypass_d = 1'b0;
                IR_SET_ADDR: sr_d = addr_q;
                IR_WRITE:    sr_d = '0;
                default: begin
                    sr_d              = '0;
                    sr_d[DATA_W-1:0]  = mem_rdata;
                end
            endcase
        end else if (virtual_state_sdr && state_q == ST_ARMED) begin
            if (ir == IR_BYPASS) begin
                bypass_d = tdi;
            end else begin
                sr_d = sr_q >> 1;
                if (ir == IR_SET_ADDR) sr_d[ADDR_W-1] = tdi;
                else                   sr_d[DATA_W-1] = tdi;
            end
        end

        // Write increments during its strobe cycle, after using the old address.
        if (load_addr)     addr_d = sr_q;
        else if (inc_addr) addr_d = addr_q + 1'b1;

        if (virtual_state_uir && ir == IR_SET_ADDR) wrap_d = 1'b0;
        if (inc_addr && !load_addr && (&addr_q))    wrap_d = 1'b1;
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            sr_q     <= '0;
            bypass_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wrap_q   <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            sr_q     <= sr_d;
            bypass_q <= bypass_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            wrap_q   <= wrap_d;
            state_q  <= state_d;
        end
    end

    assign tdo       = (ir == IR_BYPASS) ? bypass_q : sr_q[0];
    assign ir_out    = {1'b1, wrap_q};
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;

endmodule

// File: doc/vjtag_mem_bridge.md
VJTAG_MEM_BRIDGE -- requirements
Module: vjtag_mem_bridge

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 16, meaning the memory address width in bits (ADDR_W >= DATA_W).
REQ-002 The block SHALL expose parameter DATA_W, default 8, meaning the memory data (pixel) width in bits.
REQ-003 Port tck, input, 1 bit: the single clock; all state SHALL be on rising tck.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port tdi, input, 1 bit: serial data from the virtual JTAG hub.
REQ-006 Port tdo, output, 1 bit: serial data to the virtual JTAG hub.
REQ-007 Port ir_in, input, 2 bits: current virtual instruction.
REQ-008 Port ir_out, output, 2 bits: status captured by the hub in the Capture-IR state.
REQ-009 Ports virtual_state_cdr, virtual_state_sdr, virtual_state_udr and virtual_state_uir, input, 1 bit each: one-cycle TAP state indications.
REQ-010 Ports virtual_state_e1dr, virtual_state_pdr, virtual_state_e2dr and virtual_state_cir, input, 1 bit each: accepted and ignored.
REQ-011 Port mem_addr, output, ADDR_W bits: memory address.
REQ-012 Port mem_wdata, output, DATA_W bits: memory write data.
REQ-013 Port mem_we, output, 1 bit: single-cycle write strobe.
REQ-014 Port mem_rdata, input, DATA_W bits: synchronous-read data, valid one tck after mem_addr.

Function
REQ-015 The instruction encoding SHALL be: 00 BYPASS, 01 SET_ADDR, 10 WRITE, 11 READ.
REQ-016 The DR length SHALL be 1 bit for BYPASS, ADDR_W bits for SET_ADDR, and DATA_W bits for WRITE and READ.
REQ-017 The block SHALL hold an ADDR_W-bit shift register sr and a 1-bit bypass register.
REQ-018 In virtual_state_sdr, sr SHALL shift right by one, with tdi entering bit (DR length - 1) of the current instruction; bits above that position SHALL be don't-care.
REQ-019 tdo SHALL be driven by sr[0] for SET_ADDR, WRITE and READ, and by the bypass register for BYPASS; tdo SHALL be a registered value only, with no combinational path from tdi.
REQ-020 In virtual_state_cdr with READ, sr[DATA_W-1:0] SHALL load mem_rdata.
REQ-021 In virtual_state_cdr with SET_ADDR, sr SHALL load the current mem_addr for readback.
REQ-022 In virtual_state_cdr with WRITE, sr SHALL load zero.
REQ-023 In virtual_state_udr with SET_ADDR, mem_addr SHALL load sr[ADDR_W-1:0].
REQ-024 In virtual_state_udr with WRITE, mem_wdata SHALL load sr[DATA_W-1:0] and mem_we SHALL be 1 for exactly the next cycle; mem_addr SHALL increment by 1 on the cycle that mem_we is high, i.e. after the write uses the old address.
REQ-025 In virtual_state_udr with READ, mem_addr SHALL increment by 1, pre-fetching the next datum for the following Capture-DR.
REQ-026 The address SHALL wrap modulo 2^ADDR_W; an increment from all-ones SHALL set a sticky wrap flag.
REQ-027 ir_out SHALL be {1'b1, wrap flag}; bit 1 is a constant alive marker.
REQ-028 virtual_state_uir with ir_in == SET_ADDR SHALL clear the wrap flag; if a wrap occurs in the same cycle, set SHALL win.
REQ-029 Update-DR with BYPASS SHALL have no effect on mem_addr, mem_we, mem_wdata or the wrap flag.
REQ-030 Simultaneous state strobes are illegal hub behaviour; if they occur, precedence SHALL be udr > cdr > sdr.

Reset
REQ-031 While rst_n = 0, the outputs and state SHALL be: sr = 0, bypass = 0, mem_addr = 0, mem_wdata = 0, mem_we = 0, wrap flag = 0, tdo = 0, ir_out = 2'b10.
REQ-032 Reset mid-shift SHALL discard the partial DR and SHALL issue no write.
REQ-033 Reset SHALL deassert mem_we immediately and asynchronously.

Structure
REQ-034 Instruction encodings (BYPASS, SET_ADDR, WRITE, READ) and the default widths SHALL be constants in the shared package vjtag_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; memory is external.

Verification
REQ-036 SET_ADDR scenario: shift 0x1234 LSB first, then UDR -> mem_addr = 0x1234; the next SET_ADDR capture SHALL shift out 0x1234.
REQ-037 WRITE scenario: three WRITE DRs of 0xA1, 0xB2, 0xC3 from address 0x0010 -> mem_we pulses at addresses 0x0010, 0x0011, 0x0012 with the matching data, one cycle each, and final mem_addr = 0x0013.
REQ-038 READ scenario: memory model holds 0x55 at 0x0020 and 0x66 at 0x0021; SET_ADDR 0x0020 then two READ DRs -> tdo streams 0x55 then 0x66, LSB first, and final mem_addr = 0x0022.
REQ-039 Wrap scenario: SET_ADDR 0xFFFF then WRITE 0x7E -> write lands at 0xFFFF, mem_addr = 0x0000, ir_out = 2'b11; a following UIR with SET_ADDR -> ir_out = 2'b10.
REQ-040 BYPASS scenario: shift 1,0,1,1 -> tdo echoes the same pattern one cycle later, with no mem_we and mem_addr unchanged.
REQ-041 Reset scenario: assert rst_n low for one cycle midway through a WRITE shift, then complete UDR -> no mem_we, and all outputs at their reset values.
